// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared prescaled timebase, per-channel left/right/window modes,
// with double-buffered configuration that switches only at a period boundary.
module pwm_multi_gen #(
  parameter int NCH = 4,
  parameter int W   = 16,
  parameter int PSW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PSW-1:0]     prescale,
  input  logic [W-1:0]       period,
  input  logic [2*NCH-1:0]   mode,
  input  logic [W*NCH-1:0]   cmp1,
  input  logic [W*NCH-1:0]   cmp2,
  input  logic [NCH-1:0]     pol,
  input  logic               upd_req,
  output logic               upd_pend,
  output logic [W-1:0]       cnt,
  output logic               period_end,
  output logic [NCH-1:0]     pwm_out
);

  logic [PSW-1:0]   pre_cnt;
  logic [W-1:0]     period_a;
  logic [2*NCH-1:0] mode_a;
  logic [W*NCH-1:0] cmp1_a;
  logic [W*NCH-1:0] cmp2_a;
  logic [NCH-1:0]   pol_a;

  logic             tick;
  logic             wrap;
  logic             load_a;
  logic [NCH-1:0]   raw_p0;

  // Right mode compares at W+1 bits so cnt+cmp1 cannot wrap around.
  function automatic logic raw_level(input logic [1:0]   md,
                                     input logic [W-1:0] c,
                                     input logic [W-1:0] c1,
                                     input logic [W-1:0] c2,
                                     input logic [W-1:0] per);
    logic [W:0] sum;
    sum = {1'b0, c} + {1'b0, c1};
    case (md)
      2'b00:   return (c < c1);
      2'b01:   return (sum > {1'b0, per});
      2'b10:   return (c >= c1) && (c < c2);
      default: return 1'b0;
    endcase
  endfunction

  assign tick   = (pre_cnt == prescale);
  assign wrap   = tick && (cnt == period_a);
  assign load_a = !en || (wrap && (upd_pend || upd_req));

  // Stage p0: raw channel levels from the current count and active settings
  always_comb begin
    raw_p0 = '0;
    for (int i = 0; i < NCH; i++) begin
      raw_p0[i] = raw_level(mode_a[2*i +: 2], cnt, cmp1_a[W*i +: W],
                            cmp2_a[W*i +: W], period_a);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt  <= '0;
      cnt      <= '0;
      upd_pend <= 1'b0;
    end else if (!en) begin
      pre_cnt  <= '0;
      cnt      <= '0;
      upd_pend <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PSW'(1);
      if (wrap)
        cnt <= '0;
      else if (tick)
        cnt <= cnt + W'(1);
      // A request landing on the wrap cycle is consumed by that same wrap.
      if (wrap && (upd_pend || upd_req))
        upd_pend <= 1'b0;
      else if (upd_req)
        upd_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_a <= '0;
      mode_a   <= '0;
      cmp1_a   <= '0;
      cmp2_a   <= '0;
      pol_a    <= '0;
    end else if (load_a) begin
      period_a <= period;
      mode_a   <= mode;
      cmp1_a   <= cmp1;
      cmp2_a   <= cmp2;
      pol_a    <= pol;
    end
  end

  // Stage p1: registered pins; disabled channels park at their inactive level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out    <= '0;
      period_end <= 1'b0;
    end else if (!en) begin
      pwm_out    <= pol;
      period_end <= 1'b0;
    end else begin
      pwm_out    <= raw_p0 ^ pol_a;
      period_end <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed bench for pwm_multi_gen: table of per-channel waveforms plus hand-written
// sequences for shadow updates, prescaling, disable and asynchronous reset.
module tb_pwm_multi_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  prescale;
  logic [15:0] period;
  logic [7:0]  mode;
  logic [63:0] cmp1;
  logic [63:0] cmp2;
  logic [3:0]  pol;
  logic        upd_req;
  logic        upd_pend;
  logic [15:0] cnt;
  logic        period_end;
  logic [3:0]  pwm_out;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0]  mode;
    logic [63:0] c1;
    logic [63:0] c2;
    logic [3:0]  pol;
    logic [39:0] exp;   // channel ch level at cnt k is bit 10*ch+k
  } vec_t;

  vec_t vecs [6];

  pwm_multi_gen #(.NCH(4), .W(16), .PSW(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .prescale(prescale), .period(period),
    .mode(mode), .cmp1(cmp1), .cmp2(cmp2), .pol(pol), .upd_req(upd_req),
    .upd_pend(upd_pend), .cnt(cnt), .period_end(period_end), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cnt(input logic [15:0] tgt);
    int n;
    n = 0;
    while (cnt !== tgt && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("wait_cnt_%0d", tgt), cnt, tgt);
  endtask

  task automatic run_vec(input int i);
    logic [39:0] got;
    logic [9:0]  pe;
    got = '0;
    pe  = '0;
    @(negedge clk);
    en = 1'b0; prescale = 8'd0; period = 16'd9;
    mode = vecs[i].mode; cmp1 = vecs[i].c1; cmp2 = vecs[i].c2; pol = vecs[i].pol;
    @(negedge clk);
    chk($sformatf("v%0d_idle_pwm", i), pwm_out, vecs[i].pol);
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      pe[k] = period_end;
      for (int ch = 0; ch < 4; ch++) got[10*ch + k] = pwm_out[ch];
    end
    for (int ch = 0; ch < 4; ch++)
      chk($sformatf("v%0d_ch%0d_wave", i, ch), got[10*ch +: 10], vecs[i].exp[10*ch +: 10]);
    chk($sformatf("v%0d_period_end", i), pe, 10'h200);
  endtask

  initial begin
    logic [11:0] cv;
    logic [11:0] pev;
    logic        hi;
    logic        bad;
    logic        pend_lost;
    logic [6:0]  w;
    int          n;

    // period=9 throughout the table
    vecs[0] = '{8'hE4, 64'h0000_0002_0003_0003, 64'h0000_0005_0000_0000, 4'h0,
                {10'h000, 10'h01C, 10'h380, 10'h007}};
    vecs[1] = '{8'hA4, 64'h0005_0002_0000_0000, 64'h0002_0002_0000_0000, 4'h0,
                {10'h000, 10'h000, 10'h000, 10'h000}};
    vecs[2] = '{8'h24, 64'h0009_0000_000A_000A, 64'h0000_000A_0000_0000, 4'h0,
                {10'h1FF, 10'h3FF, 10'h3FF, 10'h3FF}};
    vecs[3] = '{8'hE4, 64'h0000_0002_0003_0003, 64'h0000_0005_0000_0000, 4'hF,
                {10'h3FF, 10'h3E3, 10'h07F, 10'h3F8}};
    vecs[4] = '{8'h24, 64'h0009_0000_000A_000A, 64'h0000_000A_0000_0000, 4'h5,
                {10'h1FF, 10'h000, 10'h3FF, 10'h000}};
    vecs[5] = '{8'hA4, 64'h0005_0002_0000_0000, 64'h0002_0002_0000_0000, 4'hF,
                {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF}};

    rst_n = 1'b0; en = 1'b0; prescale = '0; period = '0; mode = '0;
    cmp1 = '0; cmp2 = '0; pol = 4'hF; upd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pwm", pwm_out, 4'h0);
    chk("rst_cnt", cnt, 16'd0);
    chk("rst_pend", upd_pend, 1'b0);
    chk("rst_pe", period_end, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Mid-period update: old duty must hold until the wrap
    run_vec(0);
    wait_cnt(16'd4);
    cmp1[15:0] = 16'd6; upd_req = 1'b1;
    @(negedge clk);
    upd_req = 1'b0;
    chk("upd_pend_set", upd_pend, 1'b1);
    bad = 1'b0; pend_lost = 1'b0; n = 0;
    do begin
      @(negedge clk);
      n++;
      bad |= pwm_out[0];
      if (!period_end) pend_lost |= !upd_pend;
    end while (!period_end && n < 20);
    chk("upd_wrap_seen", period_end, 1'b1);
    chk("upd_old_duty_held", bad, 1'b0);
    chk("upd_pend_held", pend_lost, 1'b0);
    chk("upd_pend_clear", upd_pend, 1'b0);
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      w[j] = pwm_out[0];
    end
    chk("upd_new_duty", w, 7'h3F);

    // Request on the wrap cycle itself takes effect at that wrap
    wait_cnt(16'd9);
    cmp1[15:0] = 16'd2; upd_req = 1'b1;
    @(negedge clk);
    upd_req = 1'b0;
    chk("wrapreq_pe", period_end, 1'b1);
    chk("wrapreq_pend", upd_pend, 1'b0);
    w = '0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      w[j] = pwm_out[0];
    end
    chk("wrapreq_new_duty", w, 7'h03);

    // Prescaler: prescale=2, period=1 then period=0
    @(negedge clk);
    en = 1'b0; prescale = 8'd2; period = 16'd1;
    @(negedge clk);
    en = 1'b1;
    hi = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      cv[k] = cnt[0]; pev[k] = period_end; hi |= |cnt[15:1];
    end
    chk("ps_p1_cnt", {hi, cv}, {1'b0, 12'h71C});
    chk("ps_p1_pe", pev, 12'h820);
    @(negedge clk);
    en = 1'b0; period = 16'd0;
    @(negedge clk);
    en = 1'b1;
    hi = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      pev[k] = period_end; hi |= |cnt;
    end
    chk("ps_p0_cnt_nonzero", hi, 1'b0);
    chk("ps_p0_pe", pev, 12'h924);

    // Disable mid-period clears the count and any pending update
    run_vec(0);
    wait_cnt(16'd5);
    upd_req = 1'b1;
    @(negedge clk);
    upd_req = 1'b0;
    chk("dis_pend_before", upd_pend, 1'b1);
    en = 1'b0; pol = 4'b1010;
    @(negedge clk);
    chk("dis_cnt", cnt, 16'd0);
    chk("dis_pwm", pwm_out, 4'b1010);
    chk("dis_pend", upd_pend, 1'b0);
    chk("dis_pe", period_end, 1'b0);

    // Asynchronous reset mid-period
    run_vec(2);
    wait_cnt(16'd3);
    upd_req = 1'b1;
    @(negedge clk);
    upd_req = 1'b0;
    chk("arst_pend_before", upd_pend, 1'b1);
    chk("arst_pwm_before", pwm_out, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pwm", pwm_out, 4'h0);
    chk("arst_cnt", cnt, 16'd0);
    chk("arst_pend", upd_pend, 1'b0);
    chk("arst_pe", period_end, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_cnt", cnt, 16'd0);
    chk("post_rst_pe", period_end, 1'b1);
    chk("post_rst_pwm", pwm_out, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
